// File: rtl/vga_timing_pkg.sv
// Shared definitions for the raster timing generator: FSM encoding, standard
// timing sets and the axis-length helper.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs negative
  localparam int unsigned VGA640_H_VISIBLE = 640;
  localparam int unsigned VGA640_H_FRONT   = 16;
  localparam int unsigned VGA640_H_SYNC    = 96;
  localparam int unsigned VGA640_H_BACK    = 48;
  localparam int unsigned VGA640_V_VISIBLE = 480;
  localparam int unsigned VGA640_V_FRONT   = 10;
  localparam int unsigned VGA640_V_SYNC    = 2;
  localparam int unsigned VGA640_V_BACK    = 33;
  localparam bit          VGA640_H_POL     = 1'b0;
  localparam bit          VGA640_V_POL     = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs positive
  localparam int unsigned SVGA800_H_VISIBLE = 800;
  localparam int unsigned SVGA800_H_FRONT   = 40;
  localparam int unsigned SVGA800_H_SYNC    = 128;
  localparam int unsigned SVGA800_H_BACK    = 88;
  localparam int unsigned SVGA800_V_VISIBLE = 600;
  localparam int unsigned SVGA800_V_FRONT   = 1;
  localparam int unsigned SVGA800_V_SYNC    = 4;
  localparam int unsigned SVGA800_V_BACK    = 23;
  localparam bit          SVGA800_H_POL     = 1'b1;
  localparam bit          SVGA800_V_POL     = 1'b1;

  function automatic int unsigned axis_total(input int unsigned visible, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-tick/run inputs and raster timing outputs of the timing generator.
interface vga_timing_gen_if #(parameter int CW = 11);

  logic          clk_en;
  logic          enable;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          hsync;
  logic          vsync;
  logic          hblank;
  logic          vblank;
  logic          de;
  logic          line_start;
  logic          frame_start;
  logic          fetch_req;
  logic          running;

  modport master (
    input  clk_en, enable,
    output h_count, v_count, hsync, vsync, hblank, vblank, de,
           line_start, frame_start, fetch_req, running
  );

  modport slave (
    output clk_en, enable,
    input  h_count, v_count, hsync, vsync, hblank, vblank, de,
           line_start, frame_start, fetch_req, running
  );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: position counter with wrap plus registered blank, sync and
// last-position flags that change on the same edge as the count.
module axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE  = 640,
  parameter int unsigned FRONT    = 16,
  parameter int unsigned SYNC     = 96,
  parameter int unsigned BACK     = 48,
  parameter bit          SYNC_POL = 1'b0,
  parameter int          CW       = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_idle,
  input  logic          i_start,
  input  logic          i_step,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_next_count,
  output logic          o_blank,
  output logic          o_sync,
  output logic          o_last
);

  localparam int          W        = CW + 1;
  localparam logic [CW:0] TOTAL    = W'(axis_total(VISIBLE, FRONT, SYNC, BACK));
  localparam logic [CW:0] LAST     = TOTAL - W'(1);
  localparam logic [CW:0] VIS      = W'(VISIBLE);
  localparam logic [CW:0] SYNC_BEG = W'(VISIBLE + FRONT);
  localparam logic [CW:0] SYNC_END = W'(VISIBLE + FRONT + SYNC);

  logic [CW-1:0] r_count;
  logic          r_blank;
  logic          r_sync;
  logic          r_last;
  logic [CW-1:0] w_next;
  logic [CW:0]   w_next_ext;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_count;
    if (i_idle || i_start)  w_next = '0;
    else if (i_step)        w_next = r_last ? '0 : r_count + CW'(1);
  end

  assign w_next_ext = {1'b0, w_next};

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_blank <= 1'b1;
      r_sync  <= ~SYNC_POL;
      r_last  <= 1'b0;
    end else if (i_idle) begin
      r_count <= '0;
      r_blank <= 1'b1;
      r_sync  <= ~SYNC_POL;
      r_last  <= 1'b0;
    end else if (i_start || i_step) begin
      r_count <= w_next;
      r_blank <= (w_next_ext >= VIS);
      r_sync  <= (w_next_ext >= SYNC_BEG && w_next_ext < SYNC_END) ? SYNC_POL : ~SYNC_POL;
      r_last  <= (w_next_ext == LAST);
    end
  end

  assign o_count      = r_count;
  assign o_next_count = w_next;
  assign o_blank      = r_blank;
  assign o_sync       = r_sync;
  assign o_last       = r_last;

endmodule

// File: rtl/vga_timing_gen.sv
// Two-axis raster timing generator: run/drain FSM that starts and stops only on
// frame boundaries, line/frame pulses, display enable and pixel-fetch lookahead.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA640_H_VISIBLE,
  parameter int unsigned H_FRONT    = VGA640_H_FRONT,
  parameter int unsigned H_SYNC     = VGA640_H_SYNC,
  parameter int unsigned H_BACK     = VGA640_H_BACK,
  parameter int unsigned V_VISIBLE  = VGA640_V_VISIBLE,
  parameter int unsigned V_FRONT    = VGA640_V_FRONT,
  parameter int unsigned V_SYNC     = VGA640_V_SYNC,
  parameter int unsigned V_BACK     = VGA640_V_BACK,
  parameter bit          H_SYNC_POL = VGA640_H_POL,
  parameter bit          V_SYNC_POL = VGA640_V_POL,
  parameter int          CW         = 11,
  parameter int unsigned PREFETCH   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vif
);

  localparam int          W       = CW + 1;
  localparam logic [CW:0] H_TOTAL = W'(axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK));
  localparam logic [CW:0] V_TOTAL = W'(axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK));
  localparam logic [CW:0] H_VIS   = W'(H_VISIBLE);
  localparam logic [CW:0] V_VIS   = W'(V_VISIBLE);
  localparam logic [CW:0] PF      = W'(PREFETCH);

  state_e r_state, w_state_next;
  logic   w_idle, w_start, w_step;

  logic [CW-1:0] w_h_count, w_v_count, w_h_next, w_v_next;
  logic          w_hblank, w_vblank, w_hsync, w_vsync, w_h_last, w_v_last;
  logic          w_frame_end;

  logic r_de, r_line_start, r_frame_start, r_fetch_req, r_running;

  axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .SYNC_POL(H_SYNC_POL), .CW(CW)
  ) u_h_axis (
    .clk(clk), .reset_n(reset_n),
    .i_idle(w_idle), .i_start(w_start), .i_step(w_step),
    .o_count(w_h_count), .o_next_count(w_h_next),
    .o_blank(w_hblank), .o_sync(w_hsync), .o_last(w_h_last)
  );

  axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .SYNC_POL(V_SYNC_POL), .CW(CW)
  ) u_v_axis (
    .clk(clk), .reset_n(reset_n),
    .i_idle(w_idle), .i_start(w_start), .i_step(w_step & w_h_last),
    .o_count(w_v_count), .o_next_count(w_v_next),
    .o_blank(w_vblank), .o_sync(w_vsync), .o_last(w_v_last)
  );

  assign w_frame_end = w_h_last & w_v_last;

  // A raised enable wins over the drain-to-idle exit, so re-raising at the last pixel just wraps.
  always_comb begin
    w_state_next = r_state;
    w_idle       = 1'b0;
    w_start      = 1'b0;
    w_step       = 1'b0;
    if (vif.clk_en) begin
      unique case (r_state)
        ST_IDLE: begin
          if (vif.enable) begin
            w_state_next = ST_RUN;
            w_start      = 1'b1;
          end
        end
        ST_RUN: begin
          w_step = 1'b1;
          if (!vif.enable) w_state_next = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (vif.enable) begin
            w_step       = 1'b1;
            w_state_next = ST_RUN;
          end else if (w_frame_end) begin
            w_idle       = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_step = 1'b1;
          end
        end
        default: begin
          w_idle       = 1'b1;
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Lookahead target is PREFETCH pixels past the position about to be presented.
  logic [CW:0] w_h_ext, w_v_ext, w_fetch_h_raw, w_fetch_h, w_fetch_v;
  logic        w_fetch_wrap, w_v_next_last, w_counting_next, w_fetch_next, w_de_next;

  assign w_h_ext         = {1'b0, w_h_next};
  assign w_v_ext         = {1'b0, w_v_next};
  assign w_v_next_last   = (w_v_ext == V_TOTAL - W'(1));
  assign w_fetch_h_raw   = w_h_ext + PF;
  assign w_fetch_wrap    = (w_fetch_h_raw >= H_TOTAL);
  assign w_fetch_h       = w_fetch_wrap ? w_fetch_h_raw - H_TOTAL : w_fetch_h_raw;
  assign w_fetch_v       = !w_fetch_wrap ? w_v_ext : (w_v_next_last ? '0 : w_v_ext + W'(1));
  assign w_counting_next = (w_state_next != ST_IDLE);
  assign w_fetch_next    = w_counting_next && (w_fetch_h < H_VIS) && (w_fetch_v < V_VIS) &&
                           !(w_state_next == ST_DRAIN && w_fetch_wrap && w_v_next_last);
  assign w_de_next       = w_counting_next && (w_h_ext < H_VIS) && (w_v_ext < V_VIS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_fetch_req   <= 1'b0;
      r_running     <= 1'b0;
    end else if (vif.clk_en) begin
      r_state       <= w_state_next;
      r_de          <= w_de_next;
      r_line_start  <= w_start | (w_step & w_h_last);
      r_frame_start <= w_start | (w_step & w_frame_end);
      r_fetch_req   <= w_fetch_next;
      r_running     <= w_counting_next;
    end
  end

  assign vif.h_count     = w_h_count;
  assign vif.v_count     = w_v_count;
  assign vif.hsync       = w_hsync;
  assign vif.vsync       = w_vsync;
  assign vif.hblank      = w_hblank;
  assign vif.vblank      = w_vblank;
  assign vif.de          = r_de;
  assign vif.line_start  = r_line_start;
  assign vif.frame_start = r_frame_start;
  assign vif.fetch_req   = r_fetch_req;
  assign vif.running     = r_running;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised check of vga_timing_gen against a linear-frame-position reference
// model, on a reduced raster so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 4, HS = 3, HB = 5;
  localparam int VV = 6,  VF = 2, VS = 1, VB = 3;
  localparam bit HP = 1'b1, VP = 1'b0;
  localparam int CW = 6, PF = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(CW)) vif ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(HP), .V_SYNC_POL(VP), .CW(CW), .PREFETCH(PF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vif(vif)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the raster is a single frame-linear tick index m_p
  bit m_on    = 1'b0;
  bit m_drain = 1'b0;
  int m_p     = 0;

  int cyc = 0;
  bit prev_fs = 1'b0;
  int rises[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit cen, input bit en);
    if (!cen) return;
    if (!m_on) begin
      if (en) begin
        m_on = 1'b1; m_drain = 1'b0; m_p = 0;
      end
    end else if (m_drain && !en && m_p == FT - 1) begin
      m_on = 1'b0; m_drain = 1'b0; m_p = 0;
    end else begin
      m_p     = (m_p + 1) % FT;
      m_drain = !en;
    end
  endtask

  task automatic compare_all();
    int h, v, q, fh, fv;
    bit hb, vb, hs, vs, de, ls, fs, fr;
    if (!m_on) begin
      h = 0; v = 0; hb = 1; vb = 1; hs = !HP; vs = !VP;
      de = 0; ls = 0; fs = 0; fr = 0;
    end else begin
      h  = m_p % HT;
      v  = m_p / HT;
      hb = (h >= HV);
      vb = (v >= VV);
      hs = (h >= HV + HF && h < HV + HF + HS) ? HP : !HP;
      vs = (v >= VV + VF && v < VV + VF + VS) ? VP : !VP;
      de = !hb && !vb;
      ls = (h == 0);
      fs = (m_p == 0);
      q  = m_p + PF;
      if (q >= FT && m_drain) begin
        fr = 0;
      end else begin
        q  = q % FT;
        fh = q % HT;
        fv = q / HT;
        fr = (fh < HV) && (fv < VV);
      end
    end
    check("h_count",     vif.h_count,     h);
    check("v_count",     vif.v_count,     v);
    check("hblank",      vif.hblank,      hb);
    check("vblank",      vif.vblank,      vb);
    check("hsync",       vif.hsync,       hs);
    check("vsync",       vif.vsync,       vs);
    check("de",          vif.de,          de);
    check("line_start",  vif.line_start,  ls);
    check("frame_start", vif.frame_start, fs);
    check("fetch_req",   vif.fetch_req,   fr);
    check("running",     vif.running,     m_on);
  endtask

  task automatic tick(input bit cen, input bit en);
    @(negedge clk);
    compare_all();
    if (vif.frame_start && !prev_fs) rises.push_back(cyc);
    prev_fs = vif.frame_start;
    cyc++;
    vif.clk_en = cen;
    vif.enable = en;
    model_step(cen, en);
  endtask

  // Reset lands between edges; idle values must appear before the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    vif.clk_en = 1'b0;
    vif.enable = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    m_on = 1'b0; m_drain = 1'b0; m_p = 0;
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic measure_frame(input int div);
    rises.delete();
    prev_fs = vif.frame_start;
    for (int i = 0; i < 2 * FT * div + 8 && rises.size() < 2; i++)
      tick((i % div) == 0, 1'b1);
    if (rises.size() >= 2) check("frame_len", rises[1] - rises[0], FT * div);
    else                   check("frame_seen", rises.size(), 2);
  endtask

  initial begin
    bit en;
    vif.clk_en = 1'b0;
    vif.enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    do_reset();
    measure_frame(1);

    for (int i = 0; i < 37; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < FT + 20; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);

    for (int i = 0; i < 60; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < FT + 30; i++) tick(1'b1, 1'b1);

    do_reset();
    measure_frame(4);

    en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5000; i++) begin
        if ($urandom_range(0, 149) == 0) en = !en;
        tick($urandom_range(0, 2) != 0, en);
      end
      do_reset();
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised two-axis raster timing generator producing horizontal and vertical counters, sync, blanking, display-enable and pixel-fetch lookahead for the VGA output path. Generalises the single-axis horizontal counter: both axes live in one block, sync polarity is configurable, and start/stop happens only on frame boundaries. Sits between the pixel-clock enable source and the frame-buffer read / RGB output stage.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
- H_SYNC_POL / V_SYNC_POL, 0 / 0, active sync level (0 = active-low)
- CW, 11, counter width; must hold max(H_TOTAL, V_TOTAL) - 1
- PREFETCH, 2, lead in pixel ticks for fetch_req; 1 <= PREFETCH <= H_FRONT+H_SYNC+H_BACK
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- clk_en  in  1  pixel tick; all state advances only when high
- enable  in  1  run request, level-sensitive
- h_count  out  CW  current pixel column
- v_count  out  CW  current line
- hsync / vsync  out  1  sync, polarity per parameters
- hblank / vblank  out  1  high outside visible columns / lines
- de  out  1  display enable = ~hblank & ~vblank
- line_start  out  1  one-tick pulse at h_count == 0
- frame_start  out  1  one-tick pulse at h_count == 0 and v_count == 0
- fetch_req  out  1  pixel PREFETCH ticks ahead is visible
- running  out  1  state != IDLE

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Counters run 0..TOTAL-1, never equal TOTAL.
- Flags per position: hblank = h >= H_VISIBLE; hsync active for H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC; vertical likewise.
- FSM states IDLE, RUN, DRAIN; transitions evaluated only on clk_en:
  - IDLE: counters 0, hblank=vblank=1, de=0, syncs inactive, pulses 0. enable=1 -> RUN, outputs present position (0,0) with line_start=frame_start=1.
  - RUN: h advances; at H_TOTAL-1 h wraps to 0 and v advances; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0 with frame_start. enable=0 -> DRAIN (counting continues).
  - DRAIN: counts as RUN; enable=1 -> RUN. At (H_TOTAL-1, V_TOTAL-1) -> IDLE with idle output values instead of wrapping.
- fetch_req at position (h,v): let h' = h+PREFETCH, v' = v; if h' >= H_TOTAL then h' -= H_TOTAL, v' = (v+1) mod V_TOTAL. Asserted iff h' < H_VISIBLE and v' < V_VISIBLE and the FSM will still be counting at that position (forced 0 in IDLE; in DRAIN forced 0 for positions past frame end).
- First PREFETCH pixels of a frame started from IDLE get no fetch_req; downstream treats them as don't-care.
- Sum arithmetic in CW+1 bits; no overflow for legal parameters.

## Timing
- All outputs registered; counter values and every flag for one position update on the same clk edge (zero skew between h_count and de/sync).
- clk_en low: all outputs hold, pulses included (pulse width is one clk_en tick).
- reset_n low: immediately IDLE, counters 0, hblank=vblank=1, de=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, line_start=frame_start=fetch_req=running=0. Mid-frame reset discards position.
- enable toggling within a frame has no visible effect other than state RUN<->DRAIN.

## Structure
- Package vga_timing_pkg: localparams for 640x480@60 and 800x600@60 timing sets, FSM state encoding.
- Sub-module axis_counter (instantiated for H and V): count, wrap, step enable, and registered blank/sync/is_last for one axis; vga_timing_gen holds FSM, pulses and fetch_req.

## Test plan
- Reset, enable=1, clk_en every cycle -> frame_start at first tick, next frame_start exactly 420000 ticks later; h_count never reaches 800.
- Line 0: hsync low for h 656..751 only; hblank high for h 640..799; de high h 0..639 on v 0..479, low on v 480..524; vsync low on v 490..491.
- fetch_req with PREFETCH=2: high at h 798,799 of line 524 and h 0..637 of line 0; low at h 638..797.
- Drop enable at (100,200) -> counting continues to (799,524), then running=0, counters 0, de=0; re-raise in DRAIN -> frame wraps normally.
- clk_en 1-in-4 -> outputs change only on enabled cycles, frame length 1680000 clk cycles.
- Assert reset_n low at (300,100) asynchronously -> outputs take idle values before the next clk edge; H_SYNC_POL=1 variant -> hsync idles low, pulses high.
